sprite_blitter: RTL and testbench

- Write-side engine for Frame_Buffer (640x480, 8-bit colour, 19-bit address = y*640 + x).
- Accepts one command at a time from the NIOS port glue: a full-screen clear, or a rectangular sprite copy from sprite ROM with transparency and screen clipping.
- Drives Frame_Buffer's wraddress, data and wren directly.
- frame_displayer remains the sole reader.

---
 rtl/veggie_pkg.sv | 29 ++
 rtl/fb_addr_calc.sv | 23 ++
 rtl/sprite_blitter.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/veggie_pkg.sv
// Shared frame-buffer types and constants for the Frame_Buffer write-side blocks.
// The screen geometry, the blitter state encoding and the command opcodes are kept here.
package veggie_pkg;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int FB_AW = 19;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        BLIT,
        DRAIN,
        DONE
    } blit_state_t;

    localparam logic CMD_BLIT  = 1'b0;
    localparam logic CMD_CLEAR = 1'b1;

    // Row start address for a 640-pixel stride, built from shifts so no multiplier is needed.
    function automatic logic [FB_AW-1:0] row_base(input logic [10:0] row);
        logic [FB_AW-1:0] r;
        r = {{(FB_AW-11){1'b0}}, row};
        return (r << 9) + (r << 7);
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational (row, col) -> frame buffer address, plus a flag saying the pixel lies on screen.
// Row and column are 11 bits wide so off-screen sums never fold back onto row/column 0.
module fb_addr_calc
    import veggie_pkg::*;
#(
    parameter int SCR_W = 640,
    parameter int SCR_H = 480
) (
    input  logic [10:0]      row_i,
    input  logic [10:0]      col_i,
    output logic [FB_AW-1:0] addr_o,
    output logic             on_screen_o
);

    localparam logic [10:0] W_LIM = 11'(SCR_W);
    localparam logic [10:0] H_LIM = 11'(SCR_H);

    always_comb begin
        addr_o      = row_base(row_i) + {{(FB_AW-11){1'b0}}, col_i};
        on_screen_o = (col_i < W_LIM) && (row_i < H_LIM);
    end

endmodule

// File: rtl/sprite_blitter.sv
// Write-side engine for Frame_Buffer: full-screen clear or clipped, transparent sprite copy.
// A blit is a two-stage pipeline: ROM address issue, then the frame buffer write a cycle later.
module sprite_blitter
    import veggie_pkg::*;
#(
    parameter int         SCR_W       = 640,
    parameter int         SCR_H       = 480,
    parameter int         ROM_AW      = 16,
    parameter logic [7:0] TRANSPARENT = 8'hE3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [6:0]        cmd_w,
    input  logic [6:0]        cmd_h,
    input  logic [ROM_AW-1:0] cmd_base,
    input  logic [7:0]        cmd_color,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [18:0]       fb_wraddr,
    output logic [7:0]        fb_data,
    output logic              fb_we,
    output logic              done
);

    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(SCR_W * SCR_H - 1);

    blit_state_t       state_q, state_d;

    logic [9:0]        x_q, x_d;
    logic [6:0]        w_q, w_d;
    logic [6:0]        h_q, h_d;
    logic [6:0]        i_q, i_d;
    logic [6:0]        j_q, j_d;
    logic [10:0]       col_q, col_d;
    logic [10:0]       row_q, row_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [FB_AW-1:0]  wraddr_q, wraddr_d;
    pixel_t            clr_data_q, clr_data_d;
    logic              on_q, on_d;
    logic              s1_vld_q, s1_vld_d;

    logic              accept;
    logic              zero_size;
    logic              last_col;
    logic              last_row;
    logic              last_pix;
    logic [FB_AW-1:0]  calc_addr;
    logic              calc_on;

    assign accept    = cmd_valid && (state_q == IDLE);
    assign zero_size = (cmd_w == 7'd0) || (cmd_h == 7'd0);
    assign last_col  = (i_q == w_q - 7'd1);
    assign last_row  = (j_q == h_q - 7'd1);
    assign last_pix  = last_col && last_row;

    fb_addr_calc #(
        .SCR_W (SCR_W),
        .SCR_H (SCR_H)
    ) u_addr (
        .row_i       (row_q),
        .col_i       (col_q),
        .addr_o      (calc_addr),
        .on_screen_o (calc_on)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == CMD_CLEAR) begin
                        state_d = CLEAR;
                    end else if (zero_size) begin
                        state_d = DONE;
                    end else begin
                        state_d = BLIT;
                    end
                end
            end
            CLEAR: if (wraddr_q == LAST_ADDR) state_d = DONE;
            BLIT:  if (last_pix) state_d = DRAIN;
            DRAIN: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        fb_we     = 1'b0;
        fb_data   = clr_data_q;
        case (state_q)
            IDLE:  cmd_ready = 1'b1;
            CLEAR: fb_we = 1'b1;
            BLIT, DRAIN: begin
                // The write stage sees ROM data for the pixel issued on the previous cycle.
                fb_data = rom_data;
                fb_we   = s1_vld_q && on_q && (rom_data != TRANSPARENT);
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign rom_addr  = rom_addr_q;
    assign fb_wraddr = wraddr_q;

    always_comb begin
        x_d        = x_q;
        w_d        = w_q;
        h_d        = h_q;
        i_d        = i_q;
        j_d        = j_q;
        col_d      = col_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        wraddr_d   = wraddr_q;
        clr_data_d = clr_data_q;
        on_d       = on_q;
        s1_vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d        = cmd_x;
                    w_d        = cmd_w;
                    h_d        = cmd_h;
                    i_d        = 7'd0;
                    j_d        = 7'd0;
                    col_d      = {1'b0, cmd_x};
                    row_d      = {1'b0, cmd_y};
                    rom_addr_d = cmd_base;
                    wraddr_d   = '0;
                    clr_data_d = cmd_color;
                end
            end
            CLEAR: begin
                if (wraddr_q != LAST_ADDR) wraddr_d = wraddr_q + FB_AW'(1);
            end
            BLIT: begin
                wraddr_d = calc_addr;
                on_d     = calc_on;
                s1_vld_d = 1'b1;
                // Row-major sprite with stride w: the ROM address simply increments (mod 2^ROM_AW).
                if (!last_pix) begin
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                    if (last_col) begin
                        i_d   = 7'd0;
                        j_d   = j_q + 7'd1;
                        col_d = {1'b0, x_q};
                        row_d = row_q + 11'd1;
                    end else begin
                        i_d   = i_q + 7'd1;
                        col_d = col_q + 11'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q <= '0;
            wraddr_q   <= '0;
            clr_data_q <= '0;
            s1_vld_q   <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            wraddr_q   <= wraddr_d;
            clr_data_q <= clr_data_d;
            s1_vld_q   <= s1_vld_d;
        end
    end

    always_ff @(posedge Clk) begin
        x_q   <= x_d;
        w_q   <= w_d;
        h_q   <= h_d;
        i_q   <= i_d;
        j_q   <= j_d;
        col_q <= col_d;
        row_q <= row_d;
        on_q  <= on_d;
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: clear, blits with transparency, clipping, ROM wrap,
// zero-size commands and reset in the middle of a blit.
module tb_sprite_blitter;

    localparam int ROM_AW   = 16;
    localparam int TB_SCR_W = 640;
    // Short screen keeps a complete clear pass brief; the row stride stays 640.
    localparam int TB_SCR_H = 32;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_op = 1'b0;
    logic [9:0]        cmd_x = '0;
    logic [9:0]        cmd_y = '0;
    logic [6:0]        cmd_w = '0;
    logic [6:0]        cmd_h = '0;
    logic [ROM_AW-1:0] cmd_base = '0;
    logic [7:0]        cmd_color = '0;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [18:0]       fb_wraddr;
    logic [7:0]        fb_data;
    logic              fb_we;
    logic              done;

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    wr_t        wq[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         acc_cyc = 0;
    int         w0 = 0;
    int         d0 = 0;
    int         nchk = 0;
    int         nerr = 0;
    int         exp_a[$];
    int         exp_d[$];
    logic [7:0] rom [0:65535];

    always #10 Clk = ~Clk;

    sprite_blitter #(
        .SCR_W       (TB_SCR_W),
        .SCR_H       (TB_SCR_H),
        .ROM_AW      (ROM_AW),
        .TRANSPARENT (8'hE3)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_base  (cmd_base),
        .cmd_color (cmd_color),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .fb_wraddr (fb_wraddr),
        .fb_data   (fb_data),
        .fb_we     (fb_we),
        .done      (done)
    );

    always @(posedge Clk) begin
        rom_data <= rom[rom_addr];
        cyc      <= cyc + 1;
    end

    always @(negedge Clk) begin
        if (fb_we === 1'b1) wq.push_back('{a: int'(fb_wraddr), d: int'(fb_data), c: cyc});
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nw();
        return wq.size() - w0;
    endfunction

    function automatic int rel(input int c);
        return c - acc_cyc + 1;
    endfunction

    // Issue one command, optionally keep cmd_valid asserted with junk while busy, wait for done.
    task automatic run_cmd(input string tag, input logic op, input int x, input int y,
                           input int w, input int h, input int base, input int color,
                           input bit hold, input int budget, input int exp_lat);
        int t;
        @(negedge Clk);
        w0 = wq.size();
        d0 = done_cnt;
        cmd_op    = op;
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 7'(w);
        cmd_h     = 7'(h);
        cmd_base  = 16'(base);
        cmd_color = 8'(color);
        cmd_valid = 1'b1;
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        if (!hold) cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_x     = 10'h3FF;
        cmd_y     = 10'h155;
        cmd_w     = 7'd5;
        cmd_h     = 7'd5;
        cmd_base  = 16'h1234;
        cmd_color = 8'hAA;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge Clk);
            #1;
            t++;
            if (t == 4) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 1);
        chk({tag, "_latency"}, 32'(rel(done_cyc)), 32'(exp_lat));
        @(negedge Clk);
        #1;
        chk({tag, "_ready_after"}, 32'(cmd_ready), 1);
        chk({tag, "_done_one_cycle"}, 32'(done), 0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, 32'(nw()), 32'(exp_a.size()));
        for (int k = 0; k < exp_a.size() && k < nw(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), 32'(wq[w0+k].a), 32'(exp_a[k]));
            chk($sformatf("%s_data%0d", tag, k), 32'(wq[w0+k].d), 32'(exp_d[k]));
        end
    endtask

    initial begin
        int t;
        int bad;
        int first_bad;
        logic [7:0] v;

        for (int a = 0; a < 65536; a++) begin
            v = 8'(a * 7 + 3);
            if (v == 8'hE3) v = 8'h11;
            rom[a] = v;
        end
        for (int a = 0; a < 8; a++) rom[a] = 8'(a + 1);
        for (int a = 0; a < 4; a++) rom[16 + a] = 8'(8'h21 + a);
        for (int a = 0; a < 6; a++) rom[32 + a] = 8'(8'h31 + a);
        rom[16'hFFFE] = 8'h41;
        rom[16'hFFFF] = 8'h42;

        // Reset state, observed while reset is held.
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_fb_we", 32'(fb_we), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fb_wraddr", 32'(fb_wraddr), 0);
        chk("rst_fb_data", 32'(fb_data), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // 4x2 blit at (10,5); cmd_valid held with a junk clear while busy.
        run_cmd("blit4x2", 1'b0, 10, 5, 4, 2, 0, 0, 1'b1, 40, 10);
        exp_a = '{3210, 3211, 3212, 3213, 3850, 3851, 3852, 3853};
        exp_d = '{1, 2, 3, 4, 5, 6, 7, 8};
        check_writes("blit4x2");
        if (nw() == 8) begin
            chk("blit4x2_first_wr_cycle", 32'(rel(wq[w0].c)), 2);
            chk("blit4x2_last_wr_cycle", 32'(rel(wq[w0+7].c)), 9);
        end

        // Transparent pixel at ROM[2].
        rom[2] = 8'hE3;
        run_cmd("transp", 1'b0, 10, 5, 4, 2, 0, 0, 1'b0, 40, 10);
        exp_a = '{3210, 3211, 3213, 3850, 3851, 3852, 3853};
        exp_d = '{1, 2, 4, 5, 6, 7, 8};
        check_writes("transp");
        rom[2] = 8'h03;

        // Right-edge clipping.
        run_cmd("clip_right", 1'b0, 638, 0, 4, 1, 16, 0, 1'b0, 40, 6);
        exp_a = '{638, 639};
        exp_d = '{8'h21, 8'h22};
        check_writes("clip_right");

        // Bottom-edge clipping on the last screen row.
        run_cmd("clip_bottom", 1'b0, 100, TB_SCR_H - 1, 2, 3, 32, 0, 1'b0, 40, 8);
        exp_a = '{(TB_SCR_H - 1) * 640 + 100, (TB_SCR_H - 1) * 640 + 101};
        exp_d = '{8'h31, 8'h32};
        check_writes("clip_bottom");

        // Columns past 1023 must stay off screen rather than wrap to column 0.
        run_cmd("far_right", 1'b0, 1020, 2, 8, 1, 0, 0, 1'b0, 40, 10);
        exp_a = '{};
        exp_d = '{};
        check_writes("far_right");

        // Sprite ROM address wraps modulo 2^16.
        run_cmd("rom_wrap", 1'b0, 0, 10, 4, 1, 16'hFFFE, 0, 1'b0, 40, 6);
        exp_a = '{6400, 6401, 6402, 6403};
        exp_d = '{8'h41, 8'h42, 8'h01, 8'h02};
        check_writes("rom_wrap");

        // Zero-sized sprites complete at once with no writes.
        run_cmd("zero_w", 1'b0, 0, 0, 0, 5, 0, 0, 1'b0, 20, 1);
        exp_a = '{};
        exp_d = '{};
        check_writes("zero_w");
        run_cmd("zero_h", 1'b0, 0, 0, 3, 0, 0, 0, 1'b0, 20, 1);
        check_writes("zero_h");

        // Reset on the third write of a 64x64 blit.
        @(negedge Clk);
        w0 = wq.size();
        d0 = done_cnt;
        cmd_op    = 1'b0;
        cmd_x     = 10'd0;
        cmd_y     = 10'd0;
        cmd_w     = 7'd64;
        cmd_h     = 7'd64;
        cmd_base  = 16'h0100;
        cmd_valid = 1'b1;
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        t = 0;
        while (nw() < 3 && t < 20) begin
            @(negedge Clk);
            #1;
            t++;
        end
        chk("midrst_third_write", 32'(nw()), 3);
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        chk("midrst_fb_we", 32'(fb_we), 0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 1);
        chk("midrst_done", 32'(done), 0);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt - d0), 0);
        chk("midrst_no_more_writes", 32'(nw()), 3);

        run_cmd("after_rst", 1'b0, 1, 1, 2, 1, 0, 0, 1'b0, 40, 4);
        exp_a = '{641, 642};
        exp_d = '{1, 2};
        check_writes("after_rst");

        // Full-screen clear.
        run_cmd("clear", 1'b1, 0, 0, 0, 0, 0, 8'h1C, 1'b0, TB_SCR_W * TB_SCR_H + 20,
                TB_SCR_W * TB_SCR_H + 1);
        chk("clear_wr_count", 32'(nw()), 32'(TB_SCR_W * TB_SCR_H));
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < nw(); k++) begin
            if (wq[w0+k].a != k || wq[w0+k].d != 8'h1C || rel(wq[w0+k].c) != k + 1) begin
                if (first_bad < 0) first_bad = k;
                bad++;
            end
        end
        chk("clear_sequence_bad", 32'(bad), 0);
        if (nw() > 0) begin
            chk("clear_first_wr_cycle", 32'(rel(wq[w0].c)), 1);
            chk("clear_last_addr", 32'(wq[wq.size()-1].a), 32'(TB_SCR_W * TB_SCR_H - 1));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
